// File: rtl/uart_tx_mmio.sv
// ============================================================================
//  Module   : uart_tx_mmio
//  Purpose  : Memory-mapped 8N1 UART transmitter with a TX FIFO on the cpu
//             data port; TXDATA/STATUS/BAUDDIV register window.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] fcount_q;
    logic          ovf_q;
    logic [15:0]   baud_q;
    logic [15:0]   cnt_q;
    logic [2:0]    bcnt_q;
    logic [7:0]    shreg_q;
    logic          txd_q;
    logic [31:0]   rdata_q, rdata_d;

    logic       w_hit, w_wr_tx, w_wr_stat, w_wr_div;
    logic       w_full, w_empty, w_pop, w_push, w_ovf_set;
    logic [1:0] w_off;
    logic       w_unused;

    assign w_hit     = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_off     = addr[3:2];
    assign w_wr_tx   = wr && w_hit && (w_off == 2'd0);
    assign w_wr_stat = wr && w_hit && (w_off == 2'd1);
    assign w_wr_div  = wr && w_hit && (w_off == 2'd2);
    assign w_unused  = ^{addr[1:0], wdata[31:16]};

    assign w_full    = (fcount_q == CW'(FIFO_DEPTH));
    assign w_empty   = (fcount_q == '0);
    // The FSM draws a byte when idle, or at the last clock of a stop bit so frames abut.
    assign w_pop     = !w_empty && ((state_q == S_IDLE) ||
                                    ((state_q == S_STOP) && (cnt_q == 16'd0)));
    assign w_push    = w_wr_tx && (!w_full || w_pop);
    assign w_ovf_set = w_wr_tx && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            fcount_q <= '0;
            ovf_q    <= 1'b0;
            baud_q   <= DEFAULT_DIV;
        end else begin
            if (w_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (w_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (w_push && !w_pop) begin
                fcount_q <= fcount_q + CW'(1);
            end else if (!w_push && w_pop) begin
                fcount_q <= fcount_q - CW'(1);
            end
            ovf_q <= w_ovf_set || (ovf_q && !(w_wr_stat && wdata[3]));
            if (w_wr_div) begin
                baud_q <= wdata[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            txd_q   <= 1'b1;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    if (w_pop) begin
                        shreg_q <= mem_q[rptr_q];
                        cnt_q   <= baud_q;
                        txd_q   <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q   <= baud_q;
                        bcnt_q  <= '0;
                        txd_q   <= shreg_q[0];
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q <= baud_q;
                        if (bcnt_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bcnt_q  <= bcnt_q + 3'd1;
                            shreg_q <= {1'b0, shreg_q[7:1]};
                            txd_q   <= shreg_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == 16'd0) begin
                        if (w_pop) begin
                            shreg_q <= mem_q[rptr_q];
                            cnt_q   <= baud_q;
                            txd_q   <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rdata_d = 32'd0;
        if (w_hit) begin
            case (w_off)
                2'd1:    rdata_d = {16'd0, 8'(fcount_q), 4'd0, ovf_q, w_empty,
                                    w_full, (state_q != S_IDLE)};
                2'd2:    rdata_d = {16'd0, baud_q};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign txd   = txd_q;
    assign irq   = w_empty && (state_q == S_IDLE);

endmodule

`default_nettype wire
